multi_start_timer: RTL and testbench
====================================

MULTI_START_TIMER -- requirements
Module: multi_start_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the counter width per channel in bits (legal range 1..32).
REQ-002 SHALL have parameter CHANNELS, default 2, meaning the number of independent counter channels (legal range 1..16).
REQ-003 SHALL have port Clock  in  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port CountEn  in  1  shared count tick; a channel advances only in cycles where this is high.
REQ-006 SHALL have port Start  in  CHANNELS  per-channel start/restart request, level-sampled each cycle.
REQ-007 SHALL have port Abort  in  CHANNELS  per-channel cancel request.
REQ-008 SHALL have port Reload  in  CHANNELS  per-channel mode: 0 = one-shot, 1 = auto-reload, sampled at Start.
REQ-009 SHALL have port Length  in  WIDTH  shared terminal value, sampled into the channel on Start.
REQ-010 SHALL have port Count  out  CHANNELS*WIDTH  channel n's count on bits [n*WIDTH +: WIDTH].
REQ-011 SHALL have port Busy  out  CHANNELS  channel running.
REQ-012 SHALL have port End  out  CHANNELS  one-cycle terminal pulse.
REQ-013 SHALL have port AnyBusy  out  1  OR of all Busy bits, registered.

Function
REQ-014 Each channel SHALL have exactly two states, IDLE (Busy=0) and RUN (Busy=1).
REQ-015 Per-channel priority on a clock edge SHALL be: Abort > Start > terminal > count.
REQ-016 Start in either state SHALL:
 - set Busy=1 and Count=0;
 - latch Length into the channel terminal register and Reload into the channel mode bit;
 - produce no End.
REQ-017 In RUN with CountEn=1 and Count != terminal, Count SHALL increment by 1.
REQ-018 In RUN with CountEn=1 and Count == terminal, the channel SHALL set Count=0 and End=1 for the following cycle only; Busy SHALL go to 0 if the mode bit is 0 and stay 1 if it is 1.
REQ-019 A run SHALL therefore last terminal+1 CountEn ticks; terminal 0 means one tick; terminal 2^WIDTH-1 means full range with no overflow.
REQ-020 Abort SHALL:
 - force Busy=0 and Count=0;
 - suppress End, even when it coincides with the terminal tick or with Start;
 - have no effect on an IDLE channel beyond holding Count=0.
REQ-021 Start coinciding with the terminal tick SHALL restart the channel with no End pulse.
REQ-022 Changing Length or Reload while in RUN SHALL NOT affect the run in progress.
REQ-023 In IDLE, or with CountEn=0, Count and Busy SHALL hold their values; End SHALL be 0 in every cycle not covered by REQ-018.
REQ-024 Channels SHALL be fully independent; simultaneous events on different channels SHALL NOT interact.
REQ-025 AnyBusy SHALL equal the OR of the Busy values registered on the same edge (zero added latency relative to Busy).

Reset
REQ-026 Reset high SHALL immediately force, in every channel: Count=0, Busy=0, End=0, AnyBusy=0, terminal register=0, mode bit=0.
REQ-027 Reset asserted mid-run SHALL abandon the run without an End pulse.
REQ-028 After Reset is released, the first Start SHALL be honoured on the first rising Clock edge.

Structure
REQ-029 A shared package SHALL hold the IDLE/RUN state encoding and the WIDTH/CHANNELS range-limit constants.
REQ-030 Per-channel logic SHALL be one sub-module, start_timer_channel, instantiated CHANNELS times by a generate loop; the top level holds only the channel instances, the port slicing and the AnyBusy register.

Verification
REQ-031 The bench SHALL cover a one-shot run: WIDTH=4, Length=3, Reload=0, Start pulse, CountEn=1 continuously -> Count 0,1,2,3,0; End high exactly one cycle after the 3->0 edge; Busy low at the same time.
REQ-032 The bench SHALL cover auto-reload: Length=1, Reload=1, CountEn=1 -> Count 0,1,0,1...; End pulses every 2 cycles; Busy stays 1 until an Abort pulse, after which Busy=0, Count=0 and no End is produced.
REQ-033 The bench SHALL cover gated ticks: Length=15, CountEn high every third cycle -> End after exactly 16 CountEn ticks (48 clocks); Count never exceeds 15.
REQ-034 The bench SHALL cover collisions: Start and Abort in the same cycle -> channel IDLE, no End; Start on the terminal tick -> Count=0, Busy=1, no End.
REQ-035 The bench SHALL cover parameter latching: Length changed from 5 to 2 mid-run -> the run still ends after 6 ticks; the next Start uses 2.
REQ-036 The bench SHALL cover asynchronous reset: CHANNELS=4 with all channels running, Reset asserted between clock edges -> all outputs 0 before the next edge, and no End after release.

Source files
------------

// File: rtl/multi_start_timer_pkg.sv
// ----------------------------------------------------------------------------
// multi_start_timer_pkg
//   Shared definitions for the multi-channel start timer:
//     - chan_state_t : per-channel IDLE/RUN state encoding
//     - WIDTH_MIN/MAX, CHANNELS_MIN/MAX : legal parameter ranges
// ----------------------------------------------------------------------------
package multi_start_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

    localparam int unsigned WIDTH_MIN    = 1;
    localparam int unsigned WIDTH_MAX    = 32;
    localparam int unsigned CHANNELS_MIN = 1;
    localparam int unsigned CHANNELS_MAX = 16;

endpackage

// File: rtl/multi_start_timer_channel.sv
// ----------------------------------------------------------------------------
// start_timer_channel
//   One independent timer channel. A Start latches the terminal value and the
//   reload mode and begins counting from 0 on CountEn ticks; reaching the
//   terminal value wraps to 0 with a one-cycle End pulse and either stops
//   (one-shot) or keeps running (auto-reload). Abort cancels silently.
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   i_count_en   in   shared count tick
//   i_start      in   start/restart request
//   i_abort      in   cancel request (highest priority)
//   i_reload     in   mode sampled at start: 0 one-shot, 1 auto-reload
//   i_length     in   terminal value sampled at start
//   o_count      out  current count
//   o_busy       out  channel in RUN
//   o_end        out  one-cycle terminal pulse
//   o_busy_next  out  value Busy takes on the coming edge
// ----------------------------------------------------------------------------
module start_timer_channel
    import multi_start_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
)
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_count_en,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_reload,
    input  logic [WIDTH-1:0] i_length,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_end,
    output logic             o_busy_next
);

    chan_state_t      r_state;
    chan_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_term;
    logic [WIDTH-1:0] w_term_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             r_end;
    logic             w_end_nxt;

    // State register (and the datapath registers that move with it)
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_term  <= '0;
            r_mode  <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_term  <= w_term_nxt;
            r_mode  <= w_mode_nxt;
            r_end   <= w_end_nxt;
        end
    end

    // Next-state logic; priority Abort > Start > terminal > count
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_term_nxt  = r_term;
        w_mode_nxt  = r_mode;
        w_end_nxt   = 1'b0;

        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else if (i_start) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = '0;
            w_term_nxt  = i_length;
            w_mode_nxt  = i_reload;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_count_en) begin
                        if (r_count == r_term) begin
                            w_count_nxt = '0;
                            w_end_nxt   = 1'b1;
                            w_state_nxt = r_mode ? ST_RUN : ST_IDLE;
                        end else begin
                            w_count_nxt = r_count + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_count     = r_count;
        o_busy      = (r_state == ST_RUN);
        o_end       = r_end;
        // Exposed so the top can register AnyBusy on the same edge as Busy
        o_busy_next = (w_state_nxt == ST_RUN);
    end

endmodule

// File: rtl/multi_start_timer.sv
// ----------------------------------------------------------------------------
// multi_start_timer
//   CHANNELS independent start timers sharing one count tick and one length
//   input, plus a registered OR of all busy flags.
//
// Ports
//   Clock    in   system clock, rising edge
//   Reset    in   asynchronous, active-high reset
//   CountEn  in   shared count tick
//   Start    in   [CHANNELS]        per-channel start/restart
//   Abort    in   [CHANNELS]        per-channel cancel
//   Reload   in   [CHANNELS]        per-channel mode (0 one-shot, 1 reload)
//   Length   in   [WIDTH]           shared terminal value
//   Count    out  [CHANNELS*WIDTH]  channel n on bits [n*WIDTH +: WIDTH]
//   Busy     out  [CHANNELS]        channel running
//   End      out  [CHANNELS]        one-cycle terminal pulse
//   AnyBusy  out  OR of Busy, registered alongside Busy
// ----------------------------------------------------------------------------
module multi_start_timer
    import multi_start_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 2
)
(
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      CountEn,
    input  logic [CHANNELS-1:0]       Start,
    input  logic [CHANNELS-1:0]       Abort,
    input  logic [CHANNELS-1:0]       Reload,
    input  logic [WIDTH-1:0]          Length,
    output logic [CHANNELS*WIDTH-1:0] Count,
    output logic [CHANNELS-1:0]       Busy,
    output logic [CHANNELS-1:0]       End,
    output logic                      AnyBusy
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("multi_start_timer: WIDTH out of range");
    end
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("multi_start_timer: CHANNELS out of range");
    end

    logic [CHANNELS-1:0] w_busy_next;
    logic                r_any_busy;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        start_timer_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .Clock       (Clock),
            .Reset       (Reset),
            .i_count_en  (CountEn),
            .i_start     (Start[gi]),
            .i_abort     (Abort[gi]),
            .i_reload    (Reload[gi]),
            .i_length    (Length),
            .o_count     (Count[gi*WIDTH +: WIDTH]),
            .o_busy      (Busy[gi]),
            .o_end       (End[gi]),
            .o_busy_next (w_busy_next[gi])
        );
    end

    // Built from the channels' next Busy values so it lands on the same edge
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_any_busy <= 1'b0;
        end else begin
            r_any_busy <= |w_busy_next;
        end
    end

    assign AnyBusy = r_any_busy;

endmodule

// File: tb/tb_multi_start_timer.sv
// ----------------------------------------------------------------------------
// tb_multi_start_timer
//   Self-checking bench for multi_start_timer (WIDTH=4, CHANNELS=4).
//   A behavioural model predicts every cycle's outputs into a scoreboard
//   queue; directed scenarios add explicit expectations on top.
// ----------------------------------------------------------------------------
module tb_multi_start_timer;

    localparam int unsigned W = 4;
    localparam int unsigned N = 4;

    logic           Clock;
    logic           Reset;
    logic           CountEn;
    logic [N-1:0]   Start;
    logic [N-1:0]   Abort;
    logic [N-1:0]   Reload;
    logic [W-1:0]   Length;
    logic [N*W-1:0] Count;
    logic [N-1:0]   Busy;
    logic [N-1:0]   End;
    logic           AnyBusy;

    multi_start_timer #(
        .WIDTH    (W),
        .CHANNELS (N)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .CountEn (CountEn),
        .Start   (Start),
        .Abort   (Abort),
        .Reload  (Reload),
        .Length  (Length),
        .Count   (Count),
        .Busy    (Busy),
        .End     (End),
        .AnyBusy (AnyBusy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [N*W-1:0] count;
        logic [N-1:0]   busy;
        logic [N-1:0]   endp;
        logic           any;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_tests;
    int unsigned n_fail;

    // Model state
    int unsigned m_count [N];
    int unsigned m_term  [N];
    bit          m_busy  [N];
    bit          m_mode  [N];
    bit          m_end   [N];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int unsigned c = 0; c < N; c++) begin
            m_count[c] = 0;
            m_term[c]  = 0;
            m_busy[c]  = 1'b0;
            m_mode[c]  = 1'b0;
            m_end[c]   = 1'b0;
        end
    endtask

    // Advance the model by one edge using the inputs currently driven
    task automatic model_step();
        exp_t e;
        e.count = '0;
        e.busy  = '0;
        e.endp  = '0;
        e.any   = 1'b0;
        for (int unsigned c = 0; c < N; c++) begin
            m_end[c] = 1'b0;
            if (Abort[c]) begin
                m_busy[c]  = 1'b0;
                m_count[c] = 0;
            end else if (Start[c]) begin
                m_busy[c]  = 1'b1;
                m_count[c] = 0;
                m_term[c]  = int'(Length);
                m_mode[c]  = Reload[c];
            end else if (m_busy[c] && CountEn) begin
                if (m_count[c] == m_term[c]) begin
                    m_count[c] = 0;
                    m_end[c]   = 1'b1;
                    m_busy[c]  = m_mode[c];
                end else begin
                    m_count[c] = m_count[c] + 1;
                end
            end
            e.count[c*W +: W] = m_count[c][W-1:0];
            e.busy[c] = m_busy[c];
            e.endp[c] = m_end[c];
            e.any     = e.any | m_busy[c];
        end
        sb_q.push_back(e);
    endtask

    // One clock: predict, wait for the edge, compare just after it
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge Clock);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("sb_count", 32'(Count),   32'(e.count));
            check_eq("sb_busy",  32'(Busy),    32'(e.busy));
            check_eq("sb_end",   32'(End),     32'(e.endp));
            check_eq("sb_any",   32'(AnyBusy), 32'(e.any));
        end
    endtask

    function automatic logic [W-1:0] ch_count(input int unsigned c);
        return Count[c*W +: W];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [W-1:0] exp_seq [4];
        int unsigned  n_end;
        int unsigned  clocks;
        int unsigned  ticks;
        bit           found;

        n_tests = 0;
        n_fail  = 0;
        Reset   = 1'b1;
        CountEn = 1'b0;
        Start   = '0;
        Abort   = '0;
        Reload  = '0;
        Length  = '0;
        model_reset();

        // Reset state
        #3;
        check_eq("rst_count", 32'(Count),   32'd0);
        check_eq("rst_busy",  32'(Busy),    32'd0);
        check_eq("rst_end",   32'(End),     32'd0);
        check_eq("rst_any",   32'(AnyBusy), 32'd0);
        #4;
        Reset = 1'b0;

        // One-shot, Length=3 on channel 0; Start honoured on first edge
        Start = 4'b0001; Length = 4'd3; Reload = '0; CountEn = 1'b1;
        cycle();
        check_eq("os_start_busy",  32'(Busy[0]),     32'd1);
        check_eq("os_start_count", 32'(ch_count(0)), 32'd0);
        Start = '0;
        exp_seq[0] = 4'd1; exp_seq[1] = 4'd2; exp_seq[2] = 4'd3; exp_seq[3] = 4'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            cycle();
            check_eq("os_count", 32'(ch_count(0)), 32'(exp_seq[i]));
            check_eq("os_end",   32'(End[0]),      (i == 3) ? 32'd1 : 32'd0);
        end
        check_eq("os_busy_done", 32'(Busy[0]), 32'd0);
        cycle();
        check_eq("os_end_once", 32'(End[0]), 32'd0);

        // Auto-reload, Length=1 on channel 1; Reload changed mid-run is ignored
        Start = 4'b0010; Length = 4'd1; Reload = 4'b0010;
        cycle();
        Start = '0; Reload = '0;
        n_end = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            cycle();
            if (End[1]) n_end++;
        end
        check_eq("ar_ends", n_end, 32'd3);
        check_eq("ar_busy", 32'(Busy[1]), 32'd1);
        Abort = 4'b0010;
        cycle();
        check_eq("ar_abort_busy",  32'(Busy[1]),     32'd0);
        check_eq("ar_abort_count", 32'(ch_count(1)), 32'd0);
        check_eq("ar_abort_end",   32'(End[1]),      32'd0);
        Abort = '0;
        cycle();
        check_eq("ar_after_end", 32'(End[1]), 32'd0);

        // Gated ticks: Length=15, CountEn every third clock
        Start = 4'b0001; Length = 4'd15; CountEn = 1'b0;
        cycle();
        Start = '0;
        clocks = 0;
        found  = 1'b0;
        for (int unsigned k = 0; k < 60 && !found; k++) begin
            CountEn = ((k % 3) == 2);
            cycle();
            clocks++;
            check_eq("gate_max", 32'(ch_count(0) <= 4'd15), 32'd1);
            if (End[0]) found = 1'b1;
        end
        check_eq("gate_found",  32'(found), 32'd1);
        check_eq("gate_clocks", clocks,     32'd48);
        CountEn = 1'b1;

        // Collision: Start and Abort together on channel 2
        Start = 4'b0100; Abort = 4'b0100;
        cycle();
        check_eq("col_sa_busy", 32'(Busy[2]), 32'd0);
        check_eq("col_sa_end",  32'(End[2]),  32'd0);
        Start = '0; Abort = '0;

        // Collision: Start on the terminal tick restarts silently
        Start = 4'b0100; Length = 4'd2;
        cycle();
        Start = '0;
        cycle();
        cycle();
        check_eq("col_st_pre", 32'(ch_count(2)), 32'd2);
        Start = 4'b0100;
        cycle();
        check_eq("col_st_count", 32'(ch_count(2)), 32'd0);
        check_eq("col_st_busy",  32'(Busy[2]),     32'd1);
        check_eq("col_st_end",   32'(End[2]),      32'd0);
        Start = '0;

        // Collision: Abort on the terminal tick suppresses End
        Start = 4'b0100; Length = 4'd0;
        cycle();
        Start = '0; Abort = 4'b0100;
        cycle();
        check_eq("col_at_end",  32'(End[2]),  32'd0);
        check_eq("col_at_busy", 32'(Busy[2]), 32'd0);
        Abort = '0;

        // Parameter latching on channel 3: Length changed mid-run
        Start = 4'b1000; Length = 4'd5;
        cycle();
        Start = '0; Length = 4'd2;
        ticks = 0; found = 1'b0;
        for (int unsigned k = 0; k < 20 && !found; k++) begin
            cycle();
            ticks++;
            if (End[3]) found = 1'b1;
        end
        check_eq("latch_first", ticks, 32'd6);
        Start = 4'b1000;
        cycle();
        Start = '0;
        ticks = 0; found = 1'b0;
        for (int unsigned k = 0; k < 20 && !found; k++) begin
            cycle();
            ticks++;
            if (End[3]) found = 1'b1;
        end
        check_eq("latch_second", ticks, 32'd3);

        // Independence: random activity on all channels
        for (int unsigned k = 0; k < 300; k++) begin
            Start   = N'($urandom) & N'($urandom) & N'($urandom);
            Abort   = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
            Reload  = N'($urandom);
            Length  = W'($urandom);
            CountEn = ($urandom_range(0, 3) != 0);
            cycle();
        end
        Start = '0; Abort = '0;

        // Asynchronous reset with all four channels running
        Start = 4'b1111; Length = 4'd15; Reload = 4'b1111; CountEn = 1'b1;
        cycle();
        Start = '0;
        cycle();
        cycle();
        check_eq("ar_pre_busy", 32'(Busy), 32'hF);
        #2;
        Reset = 1'b1;
        #1;
        check_eq("async_count", 32'(Count),   32'd0);
        check_eq("async_busy",  32'(Busy),    32'd0);
        check_eq("async_end",   32'(End),     32'd0);
        check_eq("async_any",   32'(AnyBusy), 32'd0);
        model_reset();
        #2;
        Reset = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            cycle();
            check_eq("post_rst_end", 32'(End), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
